video_timing_arb: RTL

//  Video raster timing generator and video-RAM slot arbiter. Produces H/V pixel

---
 rtl/video_timing_arb_if.sv | 45 ++++
 rtl/video_timing_arb.sv | 138 +++++++++++++
 2 files changed

// File: rtl/video_timing_arb_if.sv
// Pixel-side bus of the raster timing generator / VRAM slot arbiter.
// The master modport is the generator, the slave modport is the consumer/CPU side.
interface video_timing_arb_if #(
  parameter int unsigned CntW = 9
) ();
  logic            ce;
  logic            cpu_req;
  logic [CntW-1:0] hcnt;
  logic [CntW-1:0] vcnt;
  logic            hsync_n;
  logic            vsync_n;
  logic            hblank;
  logic            vblank;
  logic            ab;
  logic            cpu_ack;
  logic            cpu_wait;

  modport master (
    input  ce,
    input  cpu_req,
    output hcnt,
    output vcnt,
    output hsync_n,
    output vsync_n,
    output hblank,
    output vblank,
    output ab,
    output cpu_ack,
    output cpu_wait
  );

  modport slave (
    output ce,
    output cpu_req,
    input  hcnt,
    input  vcnt,
    input  hsync_n,
    input  vsync_n,
    input  hblank,
    input  vblank,
    input  ab,
    input  cpu_ack,
    input  cpu_wait
  );
endinterface

// File: rtl/video_timing_arb.sv
// Raster timing generator with a one-slot-per-request CPU/video VRAM arbiter.
// Syncs, blanks and the slot grant are decoded from the next count so they line up with it.
module video_timing_arb #(
  parameter int unsigned CntW    = 9,
  parameter int unsigned HTotal  = 384,
  parameter int unsigned HActive = 256,
  parameter int unsigned HsStart = 288,
  parameter int unsigned HsEnd   = 320,
  parameter int unsigned VTotal  = 264,
  parameter int unsigned VActive = 240,
  parameter int unsigned VsStart = 244,
  parameter int unsigned VsEnd   = 248
) (
  input  logic                clk,
  input  logic                rst,
  video_timing_arb_if.master  bus
);

  localparam logic [CntW-1:0] HLast    = CntW'(HTotal - 1);
  localparam logic [CntW-1:0] VLast    = CntW'(VTotal - 1);
  localparam logic [CntW-1:0] HActiveC = CntW'(HActive);
  localparam logic [CntW-1:0] HsStartC = CntW'(HsStart);
  localparam logic [CntW-1:0] HsEndC   = CntW'(HsEnd);
  localparam logic [CntW-1:0] VActiveC = CntW'(VActive);
  localparam logic [CntW-1:0] VsStartC = CntW'(VsStart);
  localparam logic [CntW-1:0] VsEndC   = CntW'(VsEnd);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StDone
  } state_e;

  logic [CntW-1:0] hcnt_q, hcnt_d;
  logic [CntW-1:0] vcnt_q, vcnt_d;
  logic            hsync_n_q, hsync_n_d;
  logic            vsync_n_q, vsync_n_d;
  logic            hblank_q, hblank_d;
  logic            vblank_q, vblank_d;
  logic            ab_q, ack_q;
  logic            grant_d;
  logic            slot_win;
  state_e          state_q, state_d;

  // Next raster position; only meaningful on a tick.
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      if (vcnt_q == VLast) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    hblank_d  = (hcnt_d >= HActiveC);
    vblank_d  = (vcnt_d >= VActiveC);
    hsync_n_d = !((hcnt_d >= HsStartC) && (hcnt_d < HsEndC));
    vsync_n_d = !((vcnt_d >= VsStartC) && (vcnt_d < VsEndC));
  end

  // The CPU may take any blanked slot, plus every fourth active pixel.
  assign slot_win = hblank_d | vblank_d | (hcnt_d[1:0] == 2'b11);

  always_comb begin
    state_d = state_q;
    if (bus.ce) begin
      unique case (state_q)
        StIdle: begin
          if (bus.cpu_req) begin
            state_d = slot_win ? StAccess : StWait;
          end
        end
        StWait: begin
          if (!bus.cpu_req) begin
            state_d = StIdle;
          end else if (slot_win) begin
            state_d = StAccess;
          end
        end
        StAccess: begin
          state_d = StDone;
        end
        StDone: begin
          if (!bus.cpu_req) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign grant_d = (state_d == StAccess);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
      ab_q      <= 1'b0;
      ack_q     <= 1'b0;
      state_q   <= StIdle;
    end else if (bus.ce) begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      ab_q      <= grant_d;
      ack_q     <= grant_d;
      state_q   <= state_d;
    end
  end

  assign bus.hcnt     = hcnt_q;
  assign bus.vcnt     = vcnt_q;
  assign bus.hsync_n  = hsync_n_q;
  assign bus.vsync_n  = vsync_n_q;
  assign bus.hblank   = hblank_q;
  assign bus.vblank   = vblank_q;
  assign bus.ab       = ab_q;
  assign bus.cpu_ack  = ack_q;
  // Wait is combinational so the CPU stalls in the same cycle it raises REQ.
  assign bus.cpu_wait = bus.cpu_req & ((state_q == StIdle) | (state_q == StWait));

endmodule
